uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_cfg_if.sv | 29 ++
 rtl/uart_rx_sampler.sv | 31 +++
 rtl/uart_rx_cfg.sv | 139 +++++++++++++
 tb/tb_uart_rx_cfg.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the configurable UART receiver.
//   rx_state_e      - receiver FSM state encoding
//   PRESCALE_*      - legal CLK-cycles-per-bit values and the fallback value
//   legal_prescale  - maps an unsupported prescale request onto the fallback
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8       = 6'd8;
  localparam logic [5:0] PRESCALE_16      = 6'd16;
  localparam logic [5:0] PRESCALE_32      = 6'd32;
  localparam logic [5:0] PRESCALE_DEFAULT = 6'd16;

  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) return p;
    return PRESCALE_DEFAULT;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line, frame configuration and result signals of the
// UART receiver.
//   slave  - receiver side: RX_IN and configuration in; P_DATA, DATA_Valid,
//            PAR_ERR, STP_ERR, BUSY out
//   master - line/configuration driver side, directions mirrored
interface uart_rx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic [5:0]            Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_Valid;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  BUSY;

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, STOP2, Prescale,
    output P_DATA, DATA_Valid, PAR_ERR, STP_ERR, BUSY
  );

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, STOP2, Prescale,
    input  P_DATA, DATA_Valid, PAR_ERR, STP_ERR, BUSY
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 3-point majority vote around the middle of a bit period.
//   CLK      - clock
//   rx_s     - synchronised serial line
//   edge_cnt - position inside the current bit period (0..P-1)
//   half     - P/2 for the latched prescale P
//   bit_q    - registered majority of the samples at P/2-1, P/2, P/2+1;
//              updated at edge_cnt = P/2+1 and held for the rest of the bit
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       rx_s,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] half,
  output logic       bit_q
);

  logic s0, s1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge CLK) begin
    if (edge_cnt == half - 6'd1) s0 <= rx_s;
    if (edge_cnt == half)        s1 <= rx_s;
    // third sample is the live line value, voted in the same cycle
    if (edge_cnt == half + 6'd1) bit_q <= majority3(s0, s1, rx_s);
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with per-frame configuration.
//   CLK, RST_n - clock, synchronous active-low reset
//   bus.RX_IN  - asynchronous serial line (idle high)
//   bus.PAR_EN / PAR_TYP / STOP2 / Prescale - frame format, latched at start detect
//   bus.P_DATA - last accepted word (LSB first on the line)
//   bus.DATA_Valid / PAR_ERR / STP_ERR - one-cycle result pulses in the DONE cycle
//   bus.BUSY   - high whenever the receiver is not idle
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          CLK,
  input logic          RST_n,
  uart_rx_cfg_if.slave bus
);

  localparam int BCW = 4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  rx_state_e              state, next_state;
  logic [5:0]             edge_cnt, p_lat, half;
  logic [BCW-1:0]         bit_cnt;
  logic                   par_en_l, par_typ_l, stop2_l;
  logic [DATA_WIDTH-1:0]  shreg, p_data;
  logic                   par_fail, stp_fail, par_fail_nxt, stp_fail_nxt;
  logic                   wait_high, bit_end, bit_q, start_det;
  logic                   data_valid, par_err, stp_err;

  // line synchroniser
  always_ff @(posedge CLK) begin
    if (!RST_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign half      = {1'b0, p_lat[5:1]};
  assign bit_end   = (edge_cnt == p_lat - 6'd1);
  // after a stop failure (e.g. a break) the line must go high before re-arming
  assign start_det = (state == ST_IDLE) && !rx_s && !wait_high;

  uart_rx_sampler u_sampler (
    .CLK      (CLK),
    .rx_s     (rx_s),
    .edge_cnt (edge_cnt),
    .half     (half),
    .bit_q    (bit_q)
  );

  always_comb begin
    next_state   = state;
    par_fail_nxt = par_fail;
    stp_fail_nxt = stp_fail;
    case (state)
      ST_IDLE:   if (start_det) next_state = ST_START;
      ST_START:  if (bit_end) next_state = bit_q ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_end && bit_cnt == BCW'(DATA_WIDTH - 1))
                   next_state = par_en_l ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) begin
                   if (bit_q != (^shreg ^ par_typ_l)) par_fail_nxt = 1'b1;
                   next_state = ST_STOP;
                 end
      ST_STOP:   if (bit_end) begin
                   if (!bit_q) stp_fail_nxt = 1'b1;
                   if (bit_cnt == {3'b000, stop2_l}) next_state = ST_DONE;
                 end
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // control state, counters and result pulses
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state      <= ST_IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      par_fail   <= 1'b0;
      stp_fail   <= 1'b0;
      wait_high  <= 1'b0;
      p_lat      <= PRESCALE_DEFAULT;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      stop2_l    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      state      <= next_state;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state == ST_IDLE || state == ST_DONE || bit_end) edge_cnt <= '0;
      else                                                 edge_cnt <= edge_cnt + 6'd1;

      if (next_state != state) bit_cnt <= '0;
      else if (bit_end)        bit_cnt <= bit_cnt + 4'd1;

      par_fail <= (state == ST_IDLE) ? 1'b0 : par_fail_nxt;
      stp_fail <= (state == ST_IDLE) ? 1'b0 : stp_fail_nxt;

      if (start_det) begin
        p_lat     <= legal_prescale(bus.Prescale);
        par_en_l  <= bus.PAR_EN;
        par_typ_l <= bus.PAR_TYP;
        stop2_l   <= bus.STOP2;
      end

      if (state == ST_DONE) wait_high <= stp_fail;
      else if (rx_s)        wait_high <= 1'b0;

      // results are registered on the edge that enters DONE
      if (state == ST_STOP && next_state == ST_DONE) begin
        if (!par_fail_nxt && !stp_fail_nxt) begin
          p_data     <= shreg;
          data_valid <= 1'b1;
        end
        par_err <= par_fail_nxt;
        stp_err <= stp_fail_nxt;
      end
    end
  end

  // data shift register, LSB arrives first
  always_ff @(posedge CLK) begin
    if (state == ST_DATA && bit_end) shreg <= {bit_q, shreg[DATA_WIDTH-1:1]};
  end

  assign bus.P_DATA     = p_data;
  assign bus.DATA_Valid = data_valid;
  assign bus.PAR_ERR    = par_err;
  assign bus.STP_ERR    = stp_err;
  assign bus.BUSY       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: bench for uart_rx_cfg with an 8-bit and a 7-bit receiver.
// Frames are serialised by send_frame, which pushes the expected outcome to a
// per-receiver queue; a monitor per receiver pops and compares on every pulse.
module tb_uart_rx_cfg;

  localparam int SYNC = 2;

  typedef struct {
    logic [8:0] data;
    logic       dv;
    logic       pe;
    logic       se;
    longint     cyc;
  } exp_t;

  logic   CLK = 1'b0;
  logic   RST_n;
  longint cyc = 0;
  int     errors = 0;
  int     checks = 0;
  exp_t   q8[$];
  exp_t   q7[$];
  exp_t   m8, m7;
  logic [8:0] last_ok [2];

  uart_rx_cfg_if #(.DATA_WIDTH(8)) if8 ();
  uart_rx_cfg_if #(.DATA_WIDTH(7)) if7 ();

  uart_rx_cfg #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (if8.slave)
  );

  uart_rx_cfg #(.DATA_WIDTH(7), .SYNC_STAGES(SYNC)) dut7 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (if7.slave)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // scoreboard monitors
  always @(posedge CLK) begin
    #1;
    if (if8.DATA_Valid === 1'b1 || if8.PAR_ERR === 1'b1 || if8.STP_ERR === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL dut8_unexpected_pulse: got dv=%0b pe=%0b se=%0b at cycle %0d, required no pulse",
                 if8.DATA_Valid, if8.PAR_ERR, if8.STP_ERR, cyc);
      end else begin
        m8 = q8.pop_front();
        if ({if8.DATA_Valid, if8.PAR_ERR, if8.STP_ERR} !== {m8.dv, m8.pe, m8.se}) begin
          errors++;
          $display("FAIL dut8_flags: got dv/pe/se=%b%b%b, required %b%b%b",
                   if8.DATA_Valid, if8.PAR_ERR, if8.STP_ERR, m8.dv, m8.pe, m8.se);
        end
        checks++;
        if (if8.P_DATA !== m8.data[7:0]) begin
          errors++;
          $display("FAIL dut8_p_data: got %h, required %h", if8.P_DATA, m8.data[7:0]);
        end
        if (m8.cyc >= 0) begin
          checks++;
          if (cyc !== m8.cyc) begin
            errors++;
            $display("FAIL dut8_latency: pulse at cycle %0d, required cycle %0d", cyc, m8.cyc);
          end
        end
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (if7.DATA_Valid === 1'b1 || if7.PAR_ERR === 1'b1 || if7.STP_ERR === 1'b1) begin
      checks++;
      if (q7.size() == 0) begin
        errors++;
        $display("FAIL dut7_unexpected_pulse: got dv=%0b pe=%0b se=%0b at cycle %0d, required no pulse",
                 if7.DATA_Valid, if7.PAR_ERR, if7.STP_ERR, cyc);
      end else begin
        m7 = q7.pop_front();
        if ({if7.DATA_Valid, if7.PAR_ERR, if7.STP_ERR} !== {m7.dv, m7.pe, m7.se}) begin
          errors++;
          $display("FAIL dut7_flags: got dv/pe/se=%b%b%b, required %b%b%b",
                   if7.DATA_Valid, if7.PAR_ERR, if7.STP_ERR, m7.dv, m7.pe, m7.se);
        end
        checks++;
        if (if7.P_DATA !== m7.data[6:0]) begin
          errors++;
          $display("FAIL dut7_p_data: got %h, required %h", if7.P_DATA, m7.data[6:0]);
        end
        if (m7.cyc >= 0) begin
          checks++;
          if (cyc !== m7.cyc) begin
            errors++;
            $display("FAIL dut7_latency: pulse at cycle %0d, required cycle %0d", cyc, m7.cyc);
          end
        end
      end
    end
  end

  task automatic drive_cfg(input int dut, input logic pen, input logic ptyp,
                           input logic stop2, input logic [5:0] psc);
    if (dut == 0) begin
      if8.PAR_EN = pen; if8.PAR_TYP = ptyp; if8.STOP2 = stop2; if8.Prescale = psc;
    end else begin
      if7.PAR_EN = pen; if7.PAR_TYP = ptyp; if7.STOP2 = stop2; if7.Prescale = psc;
    end
  endtask

  task automatic drive_rx(input int dut, input logic v);
    if (dut == 0) if8.RX_IN = v;
    else          if7.RX_IN = v;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge with the
  // line high, so consecutive calls produce frames with no idle gap.
  task automatic send_frame(input int dut, input logic [8:0] data, input logic [5:0] psc,
                            input logic pen, input logic ptyp, input logic stop2,
                            input logic flip_par, input logic [1:0] stop_val,
                            input bit timed, input bit scramble);
    int         width, period, n;
    logic       bits[$];
    logic       par;
    logic [8:0] dm;
    exp_t       e;
    width  = (dut == 0) ? 8 : 7;
    period = (psc == 6'd8 || psc == 6'd16 || psc == 6'd32) ? int'(psc) : 16;
    dm  = '0;
    par = ptyp;
    for (int i = 0; i < width; i++) begin
      dm[i] = data[i];
      par   = par ^ data[i];
    end
    bits.push_back(1'b0);
    for (int i = 0; i < width; i++) bits.push_back(data[i]);
    if (pen) bits.push_back(par ^ flip_par);
    bits.push_back(stop_val[0]);
    if (stop2) bits.push_back(stop_val[1]);
    n = bits.size();
    e.pe   = pen && flip_par;
    e.se   = !stop_val[0] || (stop2 && !stop_val[1]);
    e.dv   = !e.pe && !e.se;
    e.data = e.dv ? dm : last_ok[dut];
    if (e.dv) last_ok[dut] = dm;
    e.cyc  = timed ? cyc + 1 + SYNC + longint'(n * period) : -1;
    drive_cfg(dut, pen, ptyp, stop2, psc);
    if (dut == 0) q8.push_back(e);
    else          q7.push_back(e);
    for (int i = 0; i < n; i++) begin
      drive_rx(dut, bits[i]);
      repeat (period) @(posedge CLK);
      #1;
      if (scramble && i == 0)
        drive_cfg(dut, !pen, !ptyp, !stop2, (psc == 6'd8) ? 6'd32 : 6'd8);
    end
    drive_rx(dut, 1'b1);
  endtask

  task automatic test_reset;
    RST_n = 1'b0;
    drive_rx(0, 1'b1);
    drive_rx(1, 1'b1);
    drive_cfg(0, 1'b0, 1'b0, 1'b0, 6'd16);
    drive_cfg(1, 1'b0, 1'b0, 1'b0, 6'd16);
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (if8.P_DATA !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h, required 00", if8.P_DATA); end
    checks++; if (if8.DATA_Valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b, required 0", if8.DATA_Valid); end
    checks++; if (if8.PAR_ERR !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b, required 0", if8.PAR_ERR); end
    checks++; if (if8.STP_ERR !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b, required 0", if8.STP_ERR); end
    checks++; if (if8.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", if8.BUSY); end
    checks++; if (if7.P_DATA !== 7'h00) begin errors++; $display("FAIL reset_p_data7: got %h, required 00", if7.P_DATA); end
    checks++; if (if7.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy7: got %b, required 0", if7.BUSY); end
    last_ok[0] = '0;
    last_ok[1] = '0;
    RST_n = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  // 0xA5, P=16, even parity, one stop; configuration pins changed mid-frame
  task automatic test_basic;
    send_frame(0, 9'h0A5, 6'd16, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
    repeat (6) @(posedge CLK);
    #1;
  endtask

  // 0x3C, P=8, odd parity with the parity bit inverted
  task automatic test_parity_err;
    send_frame(0, 9'h03C, 6'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    repeat (6) @(posedge CLK);
    #1;
  endtask

  // 7-bit receiver, P=32, two stop bits: one good frame, then second stop low
  task automatic test_width7;
    send_frame(1, 9'h02B, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    send_frame(1, 9'h05A, 6'd32, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    repeat (6) @(posedge CLK);
    #1;
  endtask

  // 3-cycle low glitch while idle: back to IDLE within one bit, no pulse
  task automatic test_glitch;
    drive_cfg(0, 1'b0, 1'b0, 1'b0, 6'd16);
    drive_rx(0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    drive_rx(0, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (if8.BUSY !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b, required 1", if8.BUSY); end
    repeat (14) @(posedge CLK);
    #1;
    checks++; if (if8.BUSY !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b, required 0", if8.BUSY); end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  // 0x01 then 0xFF with no gap, Prescale pin = 10 (received as 16)
  task automatic test_back_to_back;
    send_frame(0, 9'h001, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    send_frame(0, 9'h0FF, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    repeat (8) @(posedge CLK);
    #1;
  endtask

  // line held low: one STP_ERR, then no new frame until the line goes high
  task automatic test_break;
    exp_t e;
    drive_cfg(0, 1'b0, 1'b0, 1'b0, 6'd8);
    e.data = last_ok[0];
    e.dv   = 1'b0;
    e.pe   = 1'b0;
    e.se   = 1'b1;
    e.cyc  = cyc + 1 + SYNC + 10 * 8;
    q8.push_back(e);
    drive_rx(0, 1'b0);
    repeat (120) @(posedge CLK);
    #1;
    checks++; if (if8.BUSY !== 1'b0) begin errors++; $display("FAIL break_wait_idle: got busy=%b, required 0", if8.BUSY); end
    drive_rx(0, 1'b1);
    repeat (10) @(posedge CLK);
    #1;
  endtask

  // reset during the data bits of 0x55 aborts it; 0x66 afterwards is received
  task automatic test_reset_mid;
    logic [4:0] head;
    head = 5'b01010;
    drive_cfg(0, 1'b0, 1'b0, 1'b0, 6'd16);
    for (int i = 0; i < 4; i++) begin
      drive_rx(0, head[i]);
      repeat (16) @(posedge CLK);
      #1;
    end
    RST_n = 1'b0;
    drive_rx(0, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (if8.BUSY !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", if8.BUSY); end
    checks++; if (if8.P_DATA !== 8'h00) begin errors++; $display("FAIL midreset_p_data: got %h, required 00", if8.P_DATA); end
    last_ok[0] = '0;
    last_ok[1] = '0;
    RST_n = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    send_frame(0, 9'h066, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    repeat (6) @(posedge CLK);
    #1;
  endtask

  initial begin
    if8.RX_IN = 1'b1;
    if7.RX_IN = 1'b1;
    test_reset;
    test_basic;
    test_parity_err;
    test_width7;
    test_glitch;
    test_back_to_back;
    test_break;
    test_reset_mid;
    repeat (10) @(posedge CLK);
    #1;
    checks++;
    if (q8.size() != 0) begin
      errors++;
      $display("FAIL dut8_missing_pulses: got %0d outstanding, required 0", q8.size());
    end
    checks++;
    if (q7.size() != 0) begin
      errors++;
      $display("FAIL dut7_missing_pulses: got %0d outstanding, required 0", q7.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
